uart_rx_buffer: RTL and testbench
=================================

Name: uart_rx_buffer

Overview:
- UART receive front end that feeds the byte the core datapath writes into an integer register on its UART-read instruction.
- Deserialises 8N1 serial input and queues bytes in a first-word-fall-through FIFO.
- Presents the head byte plus a valid flag to the core controller, which pops the byte once it has written the register.
- Sits between the board RX pin and the datapath `rxdata` input.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- FIFO_AW, 4, log2 of FIFO depth (depth = 16).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rxd  in  1  raw serial input, asynchronous to clk, idle high
- rxdata  out  8  FIFO head byte; drives the datapath UART input
- rx_valid  out  1  FIFO non-empty; rxdata is meaningful
- rx_pop  in  1  controller consumes the head byte this cycle
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- frame_err  out  1  sticky: stop bit sampled low
- err_clr  in  1  clears overrun and frame_err

Behaviour:
- Reset (asynchronous, rstn=0):
  - FIFO empty; rx_valid=0, rxdata=0, overrun=0, frame_err=0.
  - Receiver FSM in IDLE; bit counter and sample counter cleared.
  - Synchroniser flops set to 1 (line idle).
- Reset mid-frame discards any partial byte and all queued bytes.
- Input synchronisation: rxd passes through a 2-flop synchroniser (rxs). A third flop holds the previous value for falling-edge detection.
- Receiver FSM:
  - IDLE: a falling edge of rxs (prev=1, now=0) → START, sample counter=0.
  - START: count to CLKS_PER_BIT/2 − 1 (integer division), then sample rxs.
    - rxs=0 → DATA, bit index=0, counter=0.
    - rxs=1 → IDLE (glitch; nothing pushed, no error).
  - DATA: every CLKS_PER_BIT cycles, sample rxs into shift register bit [index], LSB first. After index 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - rxs=1 → push byte, then IDLE.
    - rxs=0 → set frame_err, discard byte, go to IDLE. A new frame starts only after rxs returns high and falls again, because the IDLE edge detector requires prev=1.
- Push latency: the byte is written at the stop-sample clock edge. rx_valid and rxdata reflect it from the next cycle.
- FIFO:
  - Depth 2^FIFO_AW.
  - Read/write pointers are FIFO_AW bits wide and wrap naturally.
  - Occupancy count is FIFO_AW+1 bits.
  - rxdata is combinational from mem[rd_ptr] (fall-through). The core samples it in the same cycle it asserts rx_pop.
- rx_pop while rx_valid=0: ignored; no pointer movement, no error.
- Push while full and no pop: byte dropped, overrun set, contents unchanged.
- Push and pop in the same cycle while full: both accepted; count stays at depth; no overrun.
- Push and pop in the same cycle while count=1: both accepted; rx_valid stays 1; rxdata shows the new byte next cycle.
- Pointer wrap: after 2^FIFO_AW push/pop pairs the pointers return to 0 with no data corruption.
- Sticky flags:
  - Set and clear take effect on the clock edge.
  - If a set event coincides with err_clr, the set wins (flag = 1).
  - Flags never clear without err_clr or reset.
- Overrun and frame errors never stall the receiver FSM.

Decomposition:
- Shared package (uart_pkg):
  - rx_state_t enum: IDLE, START, DATA, STOP.
  - UART_BYTE_W = 8.
  - Default CLKS_PER_BIT constant, so the matching TX block shares the baud setting.
- One sub-module: sync_fifo (parameters: width, address width; first-word-fall-through; push/pop/full/empty/count).
- The receiver FSM, synchroniser and error flags stay in uart_rx_buffer.

Test Plan (all scenarios use CLKS_PER_BIT=16, FIFO_AW=2):
- Single frame: send 0xA5 on rxd, no pop → rx_valid rises exactly one cycle after the stop-bit sample; rxdata=0xA5; flags 0. Then pulse rx_pop → rx_valid=0 next cycle.
- Glitch rejection: rxd low for 4 cycles then high → FSM returns to IDLE; rx_valid stays 0; frame_err=0. A following frame 0x3C is received correctly.
- Framing error: frame 0x55 with stop bit held low → frame_err=1; FIFO empty. Then assert err_clr → frame_err=0. Then send 0x81 → rxdata=0x81.
- Overrun and wrap:
  - Send 0x01–0x05 without popping → first four bytes queued; overrun=1; 0x05 absent.
  - Pop four times → rxdata sequence 0x01, 0x02, 0x03, 0x04; rx_valid=0 after.
  - Repeat once more with 0x10–0x13 and check the pointers wrap correctly.
- Simultaneous push/pop at full: fill with 0x11–0x14, pop in the stop-sample cycle of 0x15 → overrun=0; subsequent pops yield 0x12, 0x13, 0x14, 0x15.
- Async reset mid-frame: assert rstn=0 during DATA bit 3 of 0x77 with two bytes queued → all outputs 0 immediately. After release, send 0x42 → rx_valid=1 with rxdata=0x42, and no stale bytes remain.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_BYTE_W               = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic            o_full,
    output logic            o_empty,
    output logic [AW:0]     o_count
);

    localparam int c_depth = 2 ** AW;

    logic [WIDTH-1:0] r_mem [c_depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == (AW+1)'(c_depth));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer
// Description : 8N1 UART receiver feeding a FWFT byte queue for the core.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_AW      = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   rxd,
    output logic [UART_BYTE_W-1:0] rxdata,
    output logic                   rx_valid,
    input  logic                   rx_pop,
    output logic                   overrun,
    output logic                   frame_err,
    input  logic                   err_clr
);

    localparam int                c_cnt_w   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_m1  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         c_last_bit = 3'(UART_BYTE_W - 1);

    rx_state_t              r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [2:0]             r_bit_idx;
    logic [UART_BYTE_W-1:0] r_shift;
    logic                   r_sync1;
    logic                   r_rxs;
    logic                   r_rxs_prev;
    logic                   r_overrun;
    logic                   r_frame_err;

    logic                   w_stop_sample;
    logic                   w_push;
    logic                   w_frame_evt;
    logic                   w_overrun_evt;
    logic                   w_full;
    logic                   w_empty;
    logic [FIFO_AW:0]       w_count;
    logic [UART_BYTE_W-1:0] w_head;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= rxd;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_rxs_prev && !r_rxs) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    // Mid-start-bit recheck rejects short low glitches.
                    if (r_cnt == c_half_m1) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rxs ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_bit_m1) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rxs;
                        if (r_bit_idx == c_last_bit) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == c_bit_m1) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The push lands on the stop-sample edge itself, so the byte is visible next cycle.
    assign w_stop_sample = (r_state == STOP) && (r_cnt == c_bit_m1);
    assign w_push        = w_stop_sample && r_rxs;
    assign w_frame_evt   = w_stop_sample && !r_rxs;
    assign w_overrun_evt = w_push && w_full && !rx_pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_evt) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (UART_BYTE_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_pop   (rx_pop),
        .i_wdata (r_shift),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign rxdata    = w_empty ? '0 : w_head;
    assign rx_valid  = (w_count != '0);
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_buffer
// Description : Directed self-checking bench for uart_rx_buffer (16 clk/bit, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rxdata;
    logic       rx_valid;
    logic       rx_pop = 1'b0;
    logic       overrun;
    logic       frame_err;
    logic       err_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    uart_rx_buffer #(
        .CLKS_PER_BIT (16),
        .FIFO_AW      (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rxd       (rxd),
        .rxdata    (rxdata),
        .rx_valid  (rx_valid),
        .rx_pop    (rx_pop),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Frame start is driven just after edge 0; the stop bit is sampled at edge 155.
    // mode 1: check rx_valid around the stop sample; mode 2: pop during the stop-sample cycle.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int mode);
        logic [9:0] frame;
        frame = {stop_bit, d, 1'b0};
        repeat (4) @(posedge clk);
        #1 rxd = frame[0];
        for (int b = 1; b < 10; b++) begin
            repeat (16) @(posedge clk);
            #1 rxd = frame[b];
        end
        repeat (10) @(posedge clk);
        #1;
        if (mode == 1) begin
            checks++;
            if (rx_valid !== 1'b0) begin
                failures++;
                $display("FAIL valid_before_stop: got %b expected 0", rx_valid);
            end
        end
        if (mode == 2) rx_pop = 1'b1;
        @(posedge clk);
        #1 rx_pop = 1'b0;
        if (mode == 1) begin
            checks++;
            if (rx_valid !== 1'b1) begin
                failures++;
                $display("FAIL valid_after_stop: got %b expected 1", rx_valid);
            end
        end
        repeat (5) @(posedge clk);
        #1 rxd = 1'b1;
    endtask

    task automatic do_pop();
        @(posedge clk);
        #1 rx_pop = 1'b1;
        @(posedge clk);
        #1 rx_pop = 1'b0;
    endtask

    task automatic do_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_valid, rxdata, overrun, frame_err} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b data=%h ovr=%b ferr=%b expected all 0",
                     rx_valid, rxdata, overrun, frame_err);
        end
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        send_byte(8'hA5, 1'b1, 1);
        checks++;
        if (rxdata !== 8'hA5 || overrun !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL single_frame: got data=%h ovr=%b ferr=%b expected a5 0 0",
                     rxdata, overrun, frame_err);
        end
        do_pop();
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pop: got valid=%b expected 0", rx_valid);
        end
        do_pop();
        checks++;
        if (rx_valid !== 1'b0 || rxdata !== 8'h00) begin
            failures++;
            $display("FAIL pop_empty: got valid=%b data=%h expected 0 00", rx_valid, rxdata);
        end
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL glitch: got valid=%b ferr=%b expected 0 0", rx_valid, frame_err);
        end
        send_byte(8'h3C, 1'b1, 0);
        checks++;
        if (rx_valid !== 1'b1 || rxdata !== 8'h3C) begin
            failures++;
            $display("FAIL after_glitch: got valid=%b data=%h expected 1 3c", rx_valid, rxdata);
        end
        do_pop();
    endtask

    task automatic test_frame_error();
        send_byte(8'h55, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (frame_err !== 1'b1 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_set: got ferr=%b valid=%b expected 1 0", frame_err, rx_valid);
        end
        do_clr();
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_clr: got %b expected 0", frame_err);
        end
        send_byte(8'h81, 1'b1, 0);
        checks++;
        if (rx_valid !== 1'b1 || rxdata !== 8'h81 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL after_frame_err: got valid=%b data=%h ferr=%b expected 1 81 0",
                     rx_valid, rxdata, frame_err);
        end
        do_pop();
    endtask

    task automatic test_overrun_wrap();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) send_byte(8'h01 + 8'(i), 1'b1, 0);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL full_no_overrun: got %b expected 0", overrun);
        end
        send_byte(8'h05, 1'b1, 0);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h01 + 8'(i);
            checks++;
            if (rx_valid !== 1'b1 || rxdata !== exp) begin
                failures++;
                $display("FAIL overrun_pop%0d: got valid=%b data=%h expected 1 %h",
                         i, rx_valid, rxdata, exp);
            end
            do_pop();
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_drained: got valid=%b expected 0", rx_valid);
        end
        do_clr();
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clr: got %b expected 0", overrun);
        end
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1, 0);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL wrap_no_overrun: got %b expected 0", overrun);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h10 + 8'(i);
            checks++;
            if (rx_valid !== 1'b1 || rxdata !== exp) begin
                failures++;
                $display("FAIL wrap_pop%0d: got valid=%b data=%h expected 1 %h",
                         i, rx_valid, rxdata, exp);
            end
            do_pop();
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_drained: got valid=%b expected 0", rx_valid);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1, 0);
        checks++;
        if (rxdata !== 8'h11) begin
            failures++;
            $display("FAIL full_head: got %h expected 11", rxdata);
        end
        send_byte(8'h15, 1'b1, 2);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_overrun: got %b expected 0", overrun);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h12 + 8'(i);
            checks++;
            if (rx_valid !== 1'b1 || rxdata !== exp) begin
                failures++;
                $display("FAIL pushpop_pop%0d: got valid=%b data=%h expected 1 %h",
                         i, rx_valid, rxdata, exp);
            end
            do_pop();
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_drained: got valid=%b expected 0", rx_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] frame;
        send_byte(8'h5A, 1'b0, 0);
        send_byte(8'h66, 1'b1, 0);
        send_byte(8'h99, 1'b1, 0);
        checks++;
        if (rx_valid !== 1'b1 || frame_err !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state: got valid=%b ferr=%b expected 1 1", rx_valid, frame_err);
        end
        frame = {1'b1, 8'h77, 1'b0};
        @(posedge clk);
        #1 rxd = frame[0];
        for (int b = 1; b < 5; b++) begin
            repeat (16) @(posedge clk);
            #1 rxd = frame[b];
        end
        repeat (4) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        checks++;
        if ({rx_valid, rxdata, overrun, frame_err} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b data=%h ovr=%b ferr=%b expected all 0",
                     rx_valid, rxdata, overrun, frame_err);
        end
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        send_byte(8'h42, 1'b1, 0);
        checks++;
        if (rx_valid !== 1'b1 || rxdata !== 8'h42) begin
            failures++;
            $display("FAIL post_reset_byte: got valid=%b data=%h expected 1 42", rx_valid, rxdata);
        end
        do_pop();
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_stale: got valid=%b expected 0", rx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_overrun_wrap();
        test_push_pop_full();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
